// File: rtl/accel_axis_read_sequencer.sv
// Frame sequencer for the SPI accelerometer: every sample tick it reads X, Y, Z
// (CMD, ADDR, two data bytes per axis) and streams packed 16-bit words downstream.
module accel_axis_read_sequencer #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter logic [7:0]  READ_CMD   = 8'h0B,
  parameter logic [7:0]  BASE_ADDR  = 8'h0E,
  parameter int unsigned CS_SETUP   = 4,
  parameter int unsigned CS_HOLD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        spi_start,
  output logic [7:0]  spi_tx_byte,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx_byte,
  output logic        spi_cs_n,
  output logic [15:0] accel_data,
  output logic [1:0]  axis_id,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_RD0   = 3'd4,
    S_RD1   = 3'd5,
    S_HOLD  = 3'd6,
    S_PUSH  = 3'd7
  } state_t;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    axis_r;
  logic          launched_r;
  logic          cs_high_r;
  logic          abort_r;

  logic       tick_s;
  logic       stop_s;
  logic [7:0] addr_byte_s;

  assign tick_s      = enable & (timer_r == TIMER_MAX);
  assign stop_s      = abort_r | ~enable;
  assign addr_byte_s = BASE_ADDR + {5'b00000, axis_r, 1'b0};

  // Sample-rate timer: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TW{1'b0}};
    end else if (!enable || tick_s) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Sticky overrun flag: a tick that finds the sequencer busy is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (!enable) begin
      overrun <= 1'b0;
    end else if (tick_s && (state_r != S_IDLE)) begin
      overrun <= 1'b1;
    end else begin
      overrun <= overrun;
    end
  end

  // Frame sequencer; byte states launch one SPI byte in their second cycle and
  // an abort (enable low) is only honoured at byte boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CW{1'b0}};
      axis_r      <= 2'd0;
      launched_r  <= 1'b0;
      cs_high_r   <= 1'b0;
      abort_r     <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx_byte <= 8'h00;
      spi_cs_n    <= 1'b1;
      accel_data  <= 16'h0000;
      axis_id     <= 2'd0;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      frame_done <= 1'b0;
      if (!enable && (state_r != S_IDLE)) begin
        abort_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          abort_r   <= 1'b0;
          axis_r    <= 2'd0;
          cs_high_r <= 1'b0;
          if (tick_s) begin
            state_r  <= S_SETUP;
            spi_cs_n <= 1'b0;
            cnt_r    <= {CW{1'b0}};
          end
        end
        S_SETUP: begin
          if (stop_s) begin
            state_r   <= S_HOLD;
            cnt_r     <= {CW{1'b0}};
            cs_high_r <= 1'b0;
          end else if (cnt_r == SETUP_LAST) begin
            state_r     <= S_CMD;
            cnt_r       <= {CW{1'b0}};
            launched_r  <= 1'b0;
            spi_tx_byte <= READ_CMD;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_CMD: begin
          if (!launched_r) begin
            spi_start  <= 1'b1;
            launched_r <= 1'b1;
          end else if (spi_done) begin
            launched_r <= 1'b0;
            if (stop_s) begin
              state_r   <= S_HOLD;
              cnt_r     <= {CW{1'b0}};
              cs_high_r <= 1'b0;
            end else begin
              state_r     <= S_ADDR;
              spi_tx_byte <= addr_byte_s;
            end
          end
        end
        S_ADDR: begin
          if (!launched_r) begin
            spi_start  <= 1'b1;
            launched_r <= 1'b1;
          end else if (spi_done) begin
            launched_r <= 1'b0;
            if (stop_s) begin
              state_r   <= S_HOLD;
              cnt_r     <= {CW{1'b0}};
              cs_high_r <= 1'b0;
            end else begin
              state_r     <= S_RD0;
              spi_tx_byte <= 8'h00;
            end
          end
        end
        S_RD0: begin
          if (!launched_r) begin
            spi_start  <= 1'b1;
            launched_r <= 1'b1;
          end else if (spi_done) begin
            launched_r        <= 1'b0;
            accel_data[15:8]  <= spi_rx_byte;
            if (stop_s) begin
              state_r   <= S_HOLD;
              cnt_r     <= {CW{1'b0}};
              cs_high_r <= 1'b0;
            end else begin
              state_r     <= S_RD1;
              spi_tx_byte <= 8'h00;
            end
          end
        end
        S_RD1: begin
          if (!launched_r) begin
            spi_start  <= 1'b1;
            launched_r <= 1'b1;
          end else if (spi_done) begin
            launched_r      <= 1'b0;
            accel_data[7:0] <= spi_rx_byte;
            state_r         <= S_HOLD;
            cnt_r           <= {CW{1'b0}};
            cs_high_r       <= 1'b0;
          end
        end
        S_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r <= {CW{1'b0}};
            if (!cs_high_r) begin
              cs_high_r <= 1'b1;
              spi_cs_n  <= 1'b1;
            end else if (stop_s) begin
              state_r <= S_IDLE;
            end else begin
              state_r    <= S_PUSH;
              data_valid <= 1'b1;
              axis_id    <= axis_r;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_PUSH: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (stop_s) begin
              state_r <= S_IDLE;
            end else if (axis_r == 2'd2) begin
              frame_done <= 1'b1;
              state_r    <= S_IDLE;
            end else begin
              axis_r   <= axis_r + 2'd1;
              state_r  <= S_SETUP;
              spi_cs_n <= 1'b0;
              cnt_r    <= {CW{1'b0}};
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          spi_cs_n   <= 1'b1;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_axis_read_sequencer.sv
// Directed bench for accel_axis_read_sequencer: a behavioural SPI slave answers
// each byte, and monitors collect pushed words and MOSI bytes for checking.
`timescale 1ns/1ps
module tb_accel_axis_read_sequencer;

  localparam int SPI_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        spi_start;
  logic [7:0]  spi_tx_byte;
  logic        spi_done;
  logic [7:0]  spi_rx_byte;
  logic        spi_cs_n;
  logic [15:0] accel_data;
  logic [1:0]  axis_id;
  logic        data_valid;
  logic        data_ready;
  logic        frame_done;
  logic        overrun;
  logic        model_done;
  logic        spur_done;

  assign spi_done = model_done | spur_done;

  always #5 clk = ~clk;

  accel_axis_read_sequencer #(
    .SAMPLE_DIV(64), .READ_CMD(8'h0B), .BASE_ADDR(8'h0E), .CS_SETUP(4), .CS_HOLD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_done(spi_done),
    .spi_rx_byte(spi_rx_byte), .spi_cs_n(spi_cs_n),
    .accel_data(accel_data), .axis_id(axis_id), .data_valid(data_valid),
    .data_ready(data_ready), .frame_done(frame_done), .overrun(overrun)
  );

  int tests_run = 0;
  int failed    = 0;

  logic [7:0]  rx_hi [4] = '{8'hA5, 8'h12, 8'hFF, 8'hEE};
  logic [7:0]  rx_lo [4] = '{8'h3C, 8'h34, 8'h80, 8'hEE};
  logic [7:0]  exp_mosi [12] = '{8'h0B, 8'h0E, 8'h00, 8'h00,
                                 8'h0B, 8'h10, 8'h00, 8'h00,
                                 8'h0B, 8'h12, 8'h00, 8'h00};
  logic [15:0] exp_word [3] = '{16'hA53C, 16'h1234, 16'hFF80};

  logic [7:0]  mosi_q [$];
  logic [15:0] word_q [$];
  logic [1:0]  axis_q [$];
  int tx_unstable = 0;
  int start_cnt = 0, valid_cnt = 0, fd_cnt = 0;
  int cyc = 0, acc_cyc = 0, fd_cyc = 0;
  int hi_run = 0, min_gap = 1000;
  bit seen_low = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input string tag, input int max_cyc);
    int f0;
    f0 = fd_cnt;
    for (int i = 0; i < max_cyc && fd_cnt == f0; i++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, 32'(fd_cnt - f0), 32'd1);
  endtask

  // SPI slave model: answers data bytes by the axis address sent in byte 1.
  initial begin : spi_model
    int idx;
    int ax;
    logic [7:0] addr;
    logic [7:0] sent;
    logic [7:0] resp;
    model_done = 1'b0; spi_rx_byte = 8'h00; idx = 0; addr = 8'h00;
    forever begin
      @(posedge clk); #1;
      model_done = 1'b0;
      if (spi_cs_n) idx = 0;
      if (rst_n && spi_start) begin
        sent = spi_tx_byte;
        mosi_q.push_back(sent);
        if (idx == 1) addr = sent;
        case (addr)
          8'h0E:   ax = 0;
          8'h10:   ax = 1;
          8'h12:   ax = 2;
          default: ax = 3;
        endcase
        resp = (idx == 2) ? rx_hi[ax] : ((idx == 3) ? rx_lo[ax] : 8'hEE);
        idx++;
        repeat (SPI_LAT) @(posedge clk);
        #1;
        if (spi_tx_byte !== sent) tx_unstable++;
        spi_rx_byte = resp;
        model_done  = 1'b1;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_start) start_cnt++;
      if (data_valid) valid_cnt++;
      if (data_valid && data_ready) begin
        word_q.push_back(accel_data);
        axis_q.push_back(axis_id);
        acc_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (spi_cs_n) begin
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        seen_low = 1'b1;
      end
    end
  end

  initial begin : main
    int mb, wb, s0, v0, f0, bad;
    rst_n = 1'b0; enable = 1'b0; data_ready = 1'b1; spur_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_start",  32'(spi_start),   32'd0);
    check_eq("rst_tx",     32'(spi_tx_byte), 32'd0);
    check_eq("rst_cs_n",   32'(spi_cs_n),    32'd1);
    check_eq("rst_data",   32'(accel_data),  32'd0);
    check_eq("rst_axis",   32'(axis_id),     32'd0);
    check_eq("rst_valid",  32'(data_valid),  32'd0);
    check_eq("rst_fdone",  32'(frame_done),  32'd0);
    check_eq("rst_ovr",    32'(overrun),     32'd0);
    check_eq("rst_timer",  32'(dut.timer_r), 32'd0);
    check_eq("rst_state",  32'(dut.state_r), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame
    mb = mosi_q.size(); wb = word_q.size(); s0 = start_cnt; v0 = valid_cnt;
    enable = 1'b1;
    wait_frame("basic_frame_done", 400);
    check_eq("basic_overrun", 32'(overrun), 32'd1);
    enable = 1'b0;
    check_eq("basic_nwords", 32'(word_q.size() - wb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("basic_word%0d", i), 32'(word_q[wb + i]), 32'(exp_word[i]));
      check_eq($sformatf("basic_axis%0d", i), 32'(axis_q[wb + i]), 32'(i));
    end
    check_eq("basic_nmosi", 32'(mosi_q.size() - mb), 32'd12);
    for (int i = 0; i < 12; i++)
      check_eq($sformatf("basic_mosi%0d", i), 32'(mosi_q[mb + i]), 32'(exp_mosi[i]));
    check_eq("basic_starts", 32'(start_cnt - s0), 32'd12);
    check_eq("basic_valid_cycles", 32'(valid_cnt - v0), 32'd3);
    check_eq("basic_fd_latency", 32'(fd_cyc - acc_cyc), 32'd1);
    check_eq("basic_cs_gap_ge4", 32'(min_gap >= 4), 32'd1);
    check_eq("tx_stable", 32'(tx_unstable), 32'd0);
    repeat (5) @(posedge clk); #1;

    // Backpressure at Y
    mb = mosi_q.size(); wb = word_q.size();
    enable = 1'b1;
    for (int i = 0; i < 200 && word_q.size() == wb; i++) begin
      @(posedge clk); #1;
    end
    data_ready = 1'b0;
    check_eq("bp_x_accepted", 32'(word_q.size() - wb), 32'd1);
    for (int i = 0; i < 100 && !data_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("bp_valid_seen", 32'(data_valid), 32'd1);
    s0 = start_cnt; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!data_valid || accel_data !== 16'h1234 || axis_id !== 2'd1) bad++;
    end
    check_eq("bp_word_held", 32'(bad), 32'd0);
    check_eq("bp_no_start", 32'(start_cnt - s0), 32'd0);
    check_eq("bp_cs_high", 32'(spi_cs_n), 32'd1);
    check_eq("bp_overrun", 32'(overrun), 32'd1);
    data_ready = 1'b1;
    wait_frame("bp_frame_done", 200);
    check_eq("bp_nwords", 32'(word_q.size() - wb), 32'd3);
    check_eq("bp_word_y", 32'(word_q[wb + 1]), 32'h1234);
    check_eq("bp_word_z", 32'(word_q[wb + 2]), 32'hFF80);
    check_eq("bp_axis_z", 32'(axis_q[wb + 2]), 32'd2);
    check_eq("bp_nmosi", 32'(mosi_q.size() - mb), 32'd12);
    for (int i = 8; i < 12; i++)
      check_eq($sformatf("bp_mosi%0d", i), 32'(mosi_q[mb + i]), 32'(exp_mosi[i]));

    // Overrun clear by one cycle of enable low
    check_eq("ovr_before", 32'(overrun), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    check_eq("ovr_cleared", 32'(overrun), 32'd0);
    check_eq("ovr_timer0", 32'(dut.timer_r), 32'd0);
    repeat (5) @(posedge clk); #1;

    // Abort during RD0 of X
    mb = mosi_q.size(); wb = word_q.size(); s0 = start_cnt; v0 = valid_cnt; f0 = fd_cnt;
    enable = 1'b1;
    for (int i = 0; i < 200 && (start_cnt - s0) < 3; i++) begin
      @(posedge clk); #1;
    end
    enable = 1'b0;
    check_eq("ab_rd0_started", 32'(start_cnt - s0), 32'd3);
    repeat (40) @(posedge clk); #1;
    check_eq("ab_nmosi", 32'(mosi_q.size() - mb), 32'd3);
    check_eq("ab_rd0_byte", 32'(mosi_q[mb + 2]), 32'h00);
    check_eq("ab_no_valid", 32'(valid_cnt - v0), 32'd0);
    check_eq("ab_no_word", 32'(word_q.size() - wb), 32'd0);
    check_eq("ab_no_fdone", 32'(fd_cnt - f0), 32'd0);
    check_eq("ab_cs_high", 32'(spi_cs_n), 32'd1);
    check_eq("ab_idle", 32'(dut.state_r), 32'd0);

    // Re-enable, with a spurious spi_done during CS setup
    mb = mosi_q.size(); wb = word_q.size(); s0 = start_cnt;
    enable = 1'b1;
    for (int i = 0; i < 200 && spi_cs_n; i++) begin
      @(posedge clk); #1;
    end
    check_eq("re_cs_low", 32'(spi_cs_n), 32'd0);
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    wait_frame("re_frame_done", 400);
    enable = 1'b0;
    check_eq("re_nwords", 32'(word_q.size() - wb), 32'd3);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("re_word%0d", i), 32'(word_q[wb + i]), 32'(exp_word[i]));
    check_eq("re_axis0", 32'(axis_q[wb]), 32'd0);
    check_eq("re_nmosi", 32'(mosi_q.size() - mb), 32'd12);
    for (int i = 0; i < 12; i++)
      check_eq($sformatf("re_mosi%0d", i), 32'(mosi_q[mb + i]), 32'(exp_mosi[i]));
    check_eq("re_starts", 32'(start_cnt - s0), 32'd12);
    repeat (5) @(posedge clk); #1;

    // Asynchronous reset in the middle of a transaction
    enable = 1'b1;
    for (int i = 0; i < 200 && spi_cs_n; i++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_cs_n",  32'(spi_cs_n),    32'd1);
    check_eq("arst_start", 32'(spi_start),   32'd0);
    check_eq("arst_tx",    32'(spi_tx_byte), 32'd0);
    check_eq("arst_data",  32'(accel_data),  32'd0);
    check_eq("arst_valid", 32'(data_valid),  32'd0);
    check_eq("arst_axis",  32'(axis_id),     32'd0);
    check_eq("arst_ovr",   32'(overrun),     32'd0);
    check_eq("arst_state", 32'(dut.state_r), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
